uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised UART receiver. Generalises the team's fixed 8N1 receiver with:
  - configurable data width, parity and stop-bit count;
  - 3-sample majority voting and false-start rejection;
  - parity, framing and break detection;
  - an output FIFO with a read handshake.
- Sits between the board RX pin and the time-command parser that feeds the IRIG-B encoder.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 9600, baud rate.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal values 1 or 2.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, at least 2.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; asynchronous assert, active-low.
- rx  in  1  asynchronous serial input; idles high.
- rd_en  in  1  pop the FIFO head; ignored when po_valid=0.
- po_data  out  DATA_BITS  FIFO head data; LSB is the first bit received.
- po_par_err  out  1  parity error flag of the FIFO head.
- po_frm_err  out  1  framing error flag of the FIFO head.
- po_valid  out  1  FIFO not empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- overrun  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
- break_det  out  1  one-cycle pulse: break condition detected.

Behaviour:
- Reset:
  - All outputs are 0.
  - Synchroniser flops reset to 1.
  - FSM goes to IDLE; FIFO pointers are cleared.
  - A reset mid-frame discards the partial frame; no pulse is generated.
- Timing constants:
  - BAUD_CNT_MAX = CLK_FREQ/UART_BPS; MID = BAUD_CNT_MAX/2 - 1.
  - baud_cnt width is clog2(BAUD_CNT_MAX).
- Input path:
  - rx passes through a 2-FF synchroniser, then a third flop for falling-edge detect.
  - Bit value is the majority of the synchronised rx at baud_cnt = MID-1, MID and MID+1.
  - Bit decision is taken at MID+1.
- Baud counter:
  - Counts only while the FSM is not IDLE or WAIT_IDLE.
  - Wraps from BAUD_CNT_MAX-1 to 0.
  - Is zeroed on start-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE -> START on a synchronised falling edge.
  - START: decided 0 -> DATA. Decided 1 is a false start -> IDLE, with no write and no flag.
  - DATA: shifts DATA_BITS bits in, LSB first. -> PARITY if PARITY != 0, else -> STOP.
  - PARITY:
    - Odd: error if the XOR of data and the parity bit = 0.
    - Even: error if that XOR = 1.
  - STOP:
    - Samples STOP_BITS stop bits; any decided 0 sets frm_err.
    - After the last stop-bit decision the frame completes (see frame completion).
    - Goes to IDLE if the last stop bit is 1, otherwise to WAIT_IDLE.
  - WAIT_IDLE: stays until the synchronised rx = 1, then -> IDLE.
- Frame completion (same cycle as the last stop-bit decision):
  - Break: data all 0, parity bit 0 (if present) and the first stop bit 0.
    - Pulses break_det.
    - No FIFO write.
  - Otherwise, if not full or if rd_en is asserted in the same cycle:
    - Writes {frm_err, par_err, data} into the FIFO.
  - Otherwise (full, no rd_en): frame dropped and overrun pulses.
- A new falling edge is accepted from the first IDLE cycle after the stop bit. The receiver resynchronises to back-to-back frames.
- FIFO:
  - Synchronous and first-word-fall-through.
  - po_* show the head entry combinationally from the registered storage.
  - po_valid rises 1 cycle after the write cycle.
  - rd_en with po_valid=1 advances the head on the next edge.
  - Simultaneous read and write leaves the count unchanged.
  - Read when empty has no effect; pointers wrap modulo FIFO_DEPTH.
- Latency: from the end of the stop-bit MID+1 decision cycle to po_valid = 1 clock.

Decomposition:
- Package uart_pkg holds:
  - PAR_NONE / PAR_ODD / PAR_EVEN constants;
  - the FSM state encoding;
  - a baud_cnt_max(clk, bps) function;
  - a clog2 helper.
- Sub-module sync_fifo (parameters WIDTH and DEPTH) holds storage and pointers. It is reused by the future parametrised UART transmitter.

Test Plan:
- Default params, 8N1 byte 0xA5 at 9600 baud (5208 clk/bit) -> po_valid rises 1 clk after the stop decision; po_data=0xA5, both error flags 0; rd_en pulse -> po_valid=0.
- PARITY=2, DATA_BITS=7: send 0x35 with correct parity 0 -> par_err=0. Send again with parity 1 -> par_err=1 and data still 0x35.
- 1-clk glitch on rx; then a 0.3-bit low pulse -> no FIFO write and no flags; FSM is back in IDLE within 1 bit time.
- Frame with stop bit 0 and data 0x3C -> entry with frm_err=1, data 0x3C. rx low for 12 bit times -> break_det one pulse, no FIFO write; next valid 0x55 frame received correctly.
- FIFO_DEPTH=4: 5 frames with no reads -> fifo_full after the 4th, overrun pulse on the 5th. Reads then return the first 4 bytes in order.
- Assert sys_rst_n low during data bit 3 -> all outputs 0; the next complete frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the parametrised UART blocks.
package uart_pkg;

   // Parity modes
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Receive FSM encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_START     = 3'd1;
   localparam state_t ST_DATA      = 3'd2;
   localparam state_t ST_PARITY    = 3'd3;
   localparam state_t ST_STOP      = 3'd4;
   localparam state_t ST_WAIT_IDLE = 3'd5;

   // Clocks per bit period
   function automatic int baud_cnt_max(input int clk_hz, input int bps);
      return clk_hz / bps;
   endfunction

   // Ceiling log2, used for counter and pointer widths
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_param_sync_fifo.sv
// First-word-fall-through FIFO; head entry is visible whenever o_valid is high
// and reads as zero while empty.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_valid,
   output logic             o_full
);
   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_rd;
   logic             w_wr;

   // A write into a full FIFO is allowed when the head is popped in the same cycle
   assign w_rd      = i_rd_en && (r_count != '0);
   assign w_wr      = i_wr_en && ((r_count != CNT_FULL) || w_rd);
   assign o_valid   = (r_count != '0);
   assign o_full    = (r_count == CNT_FULL);
   assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;

   // Storage write port
   always_ff @(posedge sys_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-voted mid-bit sampling, false-start
// rejection, parity/framing/break detection and a FWFT output FIFO.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int UART_BPS   = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 rx,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] po_data,
   output logic                 po_par_err,
   output logic                 po_frm_err,
   output logic                 po_valid,
   output logic                 fifo_full,
   output logic                 overrun,
   output logic                 break_det
);
   localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
   localparam int MID          = BAUD_CNT_MAX / 2 - 1;
   localparam int CNT_W        = clog2(BAUD_CNT_MAX);
   localparam int BIT_W        = 4;
   localparam int ENTRY_W      = DATA_BITS + 2;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);
   localparam logic [CNT_W-1:0] SMP_A     = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] SMP_B     = CNT_W'(MID);
   localparam logic [CNT_W-1:0] SMP_C     = CNT_W'(MID + 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam bit HAS_PAR = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);

   logic                 r_rx_m, r_rx_s, r_rx_d;
   state_t               r_state;
   logic [CNT_W-1:0]     r_baud_cnt;
   logic                 r_smp_a, r_smp_b;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_par_bit, r_par_err, r_frm_err, r_stop0_zero;
   logic                 r_overrun, r_break;

   logic                 w_fall, w_active, w_decide, w_bit;
   logic                 w_last_stop, w_first_stop_zero, w_par_zero, w_is_break;
   logic                 w_frm_err, w_fifo_wr, w_drop;
   logic [ENTRY_W-1:0]   w_head;
   logic                 w_valid, w_full;

   assign w_fall   = r_rx_d & ~r_rx_s;
   assign w_active = (r_state != ST_IDLE) && (r_state != ST_WAIT_IDLE);
   assign w_decide = w_active && (r_baud_cnt == SMP_C);
   assign w_bit    = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_s) | (r_smp_b & r_rx_s);

   // Frame completion happens on the decision of the last stop bit
   assign w_last_stop       = (r_state == ST_STOP) && w_decide && (r_bit_cnt == STOP_LAST);
   assign w_first_stop_zero = (r_bit_cnt == '0) ? ~w_bit : r_stop0_zero;
   assign w_par_zero        = HAS_PAR ? ~r_par_bit : 1'b1;
   assign w_is_break        = (r_data == '0) && w_par_zero && w_first_stop_zero;
   assign w_frm_err         = r_frm_err | ~w_bit;
   assign w_fifo_wr         = w_last_stop && !w_is_break && (!w_full || rd_en);
   assign w_drop            = w_last_stop && !w_is_break && w_full && !rd_en;

   // 2-FF synchroniser plus a delay flop for falling-edge detection
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rx_m <= 1'b1;
         r_rx_s <= 1'b1;
         r_rx_d <= 1'b1;
      end else begin
         r_rx_m <= rx;
         r_rx_s <= r_rx_m;
         r_rx_d <= r_rx_s;
      end
   end

   // Baud counter runs only while a frame is in progress; held at zero otherwise
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         r_baud_cnt <= '0;
      else if (!w_active)
         r_baud_cnt <= '0;
      else
         r_baud_cnt <= (r_baud_cnt == CNT_LAST) ? '0 : r_baud_cnt + CNT_W'(1);
   end

   // Capture the first two of the three mid-bit majority samples
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_smp_a <= 1'b1;
         r_smp_b <= 1'b1;
      end else begin
         if (r_baud_cnt == SMP_A) r_smp_a <= r_rx_s;
         if (r_baud_cnt == SMP_B) r_smp_b <= r_rx_s;
      end
   end

   // Receive FSM and frame assembly
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= '0;
         r_data       <= '0;
         r_par_bit    <= 1'b0;
         r_par_err    <= 1'b0;
         r_frm_err    <= 1'b0;
         r_stop0_zero <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_state   <= ST_START;
                  r_bit_cnt <= '0;
                  r_par_bit <= 1'b0;
                  r_par_err <= 1'b0;
                  r_frm_err <= 1'b0;
               end
            end
            ST_START: begin
               if (w_decide) r_state <= w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               if (w_decide) begin
                  r_data <= {w_bit, r_data[DATA_BITS-1:1]};
                  if (r_bit_cnt == DATA_LAST) begin
                     r_bit_cnt <= '0;
                     r_state   <= HAS_PAR ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (w_decide) begin
                  r_par_bit <= w_bit;
                  r_par_err <= (PARITY == PAR_ODD) ? ~(^{r_data, w_bit}) : ^{r_data, w_bit};
                  r_state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_decide) begin
                  if (r_bit_cnt == '0) r_stop0_zero <= ~w_bit;
                  if (!w_bit) r_frm_err <= 1'b1;
                  if (r_bit_cnt == STOP_LAST) begin
                     r_bit_cnt <= '0;
                     r_state   <= w_bit ? ST_IDLE : ST_WAIT_IDLE;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  end
               end
            end
            ST_WAIT_IDLE: begin
               if (r_rx_s) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Registered one-cycle status pulses
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_overrun <= 1'b0;
         r_break   <= 1'b0;
      end else begin
         r_overrun <= w_drop;
         r_break   <= w_last_stop && w_is_break;
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .i_wr_en   (w_fifo_wr),
      .i_wr_data ({w_frm_err, r_par_err, r_data}),
      .i_rd_en   (rd_en),
      .o_rd_data (w_head),
      .o_valid   (w_valid),
      .o_full    (w_full)
   );

   assign po_data    = w_head[DATA_BITS-1:0];
   assign po_par_err = w_head[DATA_BITS];
   assign po_frm_err = w_head[DATA_BITS+1];
   assign po_valid   = w_valid;
   assign fifo_full  = w_full;
   assign overrun    = r_overrun;
   assign break_det  = r_break;

endmodule
